// File: rtl/csi2_pkt_parser_if.sv
// csi2_pkt_parser_if: merged-lane word stream in, pixel payload and packet event pulses out
interface csi2_pkt_parser_if;
  logic [15:0] word_data;
  logic        word_vld;
  logic        lp_end;
  logic [15:0] raw_data;
  logic        raw_vld;
  logic        raw_vsync;
  logic        frame_end;
  logic        packet_done;
  logic        hdr_err;
  logic        trunc_err;
  logic        crc_err;
  modport master(output word_data, word_vld, lp_end,
                 input raw_data, raw_vld, raw_vsync, frame_end, packet_done, hdr_err, trunc_err, crc_err);
  modport slave(input word_data, word_vld, lp_end,
                output raw_data, raw_vld, raw_vsync, frame_end, packet_done, hdr_err, trunc_err, crc_err);
endinterface

// File: rtl/csi2_pkt_parser.sv
// csi2_pkt_parser: CSI-2 header decode and payload forwarding for one DT/VC from the 16-bit merged lane stream
// Define CSI2_CRC_CHECK_EN to check the payload CRC-16 and drive crc_err.
module csi2_pkt_parser #(
  parameter logic [5:0] DT_PIX = 6'h2A,
  parameter logic [1:0] VC_ID  = 2'd0
) (
  input logic               sclk,
  input logic               s_rst,
  csi2_pkt_parser_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, HDR1, PAYLOAD, CRC, DROP} state_t;
  state_t      state;
  logic [15:0] w0;
  logic [14:0] wcnt;
  logic [5:0]  dt;
  logic [1:0]  vc;
  logic [15:0] wc;
  logic        pix_match;
  logic        done_now;
  assign dt        = w0[5:0];
  assign vc        = w0[7:6];
  assign wc        = {bus.word_data[7:0], w0[15:8]};
  assign pix_match = dt == DT_PIX && vc == VC_ID;
  assign done_now  = state == CRC && bus.word_vld;
`ifdef CSI2_CRC_CHECK_EN
  logic [15:0] crc, crc_nxt;
  // Reflected CRC over a whole word equals byte0 then byte1, each LSB-first
  always_comb begin
    crc_nxt = crc ^ bus.word_data;
    for (int i = 0; i < 16; i++) crc_nxt = crc_nxt[0] ? (crc_nxt >> 1) ^ 16'h8408 : crc_nxt >> 1;
  end
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      crc         <= 16'hFFFF;
      bus.crc_err <= 1'b0;
    end else begin
      crc         <= state == HDR1 ? 16'hFFFF : (state == PAYLOAD && bus.word_vld) ? crc_nxt : crc;
      bus.crc_err <= done_now && bus.word_data != crc;
    end
  end
`else
  assign bus.crc_err = 1'b0;
`endif
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state           <= IDLE;
      w0              <= '0;
      wcnt            <= '0;
      bus.raw_data    <= '0;
      bus.raw_vld     <= 1'b0;
      bus.raw_vsync   <= 1'b0;
      bus.frame_end   <= 1'b0;
      bus.packet_done <= 1'b0;
      bus.hdr_err     <= 1'b0;
      bus.trunc_err   <= 1'b0;
    end else begin
      bus.raw_vld     <= 1'b0;
      bus.raw_vsync   <= 1'b0;
      bus.frame_end   <= 1'b0;
      bus.packet_done <= 1'b0;
      bus.hdr_err     <= 1'b0;
      bus.trunc_err   <= bus.lp_end && (state == PAYLOAD || state == CRC) && !done_now;
      case (state)
        IDLE: if (bus.word_vld) begin
          w0    <= bus.word_data;
          state <= HDR1;
        end
        HDR1: if (bus.word_vld) begin
          state <= DROP;
          if (dt < 6'h10) begin
            bus.raw_vsync <= vc == VC_ID && dt == 6'h00;
            bus.frame_end <= vc == VC_ID && dt == 6'h01;
          end else if (pix_match) begin
            if (wc == 16'h0 || wc[0]) bus.hdr_err <= 1'b1;
            else begin
              wcnt  <= wc[15:1];
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: if (bus.word_vld) begin
          bus.raw_vld  <= 1'b1;
          bus.raw_data <= bus.word_data;
          wcnt         <= wcnt - 15'd1;
          if (wcnt == 15'd1) state <= CRC;
        end
        CRC: if (bus.word_vld) begin
          bus.packet_done <= 1'b1;
          state           <= DROP;
        end
        default: ;
      endcase
      // End of burst wins over any transition taken by the same-cycle word
      if (bus.lp_end) state <= IDLE;
    end
  end
endmodule
